// File: rtl/ram_pkg.sv
// Shared types and defaults for the data-RAM arbiter and its round-robin picker.
package ram_pkg;

   localparam int unsigned RAM_ADDR_W = 16;
   localparam int unsigned RAM_DATA_W = 24;

   typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
   typedef logic [RAM_DATA_W-1:0] ram_word_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RD_WAIT
   } arb_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, wrapping.
module rr_picker
   import ram_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic               valid_o
);

   always_comb begin
      int unsigned j;
      win_oh_o  = '0;
      win_idx_o = '0;
      valid_o   = 1'b0;
      j         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = (32'(rr_ptr_i) + k) % NUM_REQ;
         if (!valid_o && req_i[IDX_W'(j)]) begin
            valid_o                 = 1'b1;
            win_idx_o               = IDX_W'(j);
            win_oh_o[IDX_W'(j)]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter owning the single-port data RAM; sequences each access
// through IDLE -> ACCESS (-> RD_WAIT for reads) and returns read data per requester.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = RAM_ADDR_W,
   parameter int unsigned DATA_W  = RAM_DATA_W,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wd,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_wd,
   output logic                      ram_we,
   input  logic [DATA_W-1:0]         ram_rd
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);
   localparam int unsigned CNT_W = 2;

   arb_state_t          state_q;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]  win_oh_q, rvalid_q;
   logic                we_q, ram_we_q;
   logic [CNT_W-1:0]    lat_cnt_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]   ram_wd_q, rdata_q;

   logic [NUM_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any, sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wd;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i     (req),
      .rr_ptr_i  (rr_ptr_q),
      .win_oh_o  (pick_oh),
      .win_idx_o (pick_idx),
      .valid_o   (pick_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_wd   = '0;
      sel_we   = |(req_we & pick_oh);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_wd   = req_wd[i*DATA_W +: DATA_W];
         end
      end
      rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
   end

   // The RAM address/data registers double as the request latch, so the
   // requester may change its payload as soon as the grant cycle ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         win_oh_q   <= '0;
         we_q       <= 1'b0;
         ram_we_q   <= 1'b0;
         lat_cnt_q  <= '0;
         ram_addr_q <= '0;
         ram_wd_q   <= '0;
         rdata_q    <= '0;
         rvalid_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  win_oh_q   <= pick_oh;
                  we_q       <= sel_we;
                  ram_we_q   <= sel_we;
                  ram_addr_q <= sel_addr;
                  ram_wd_q   <= sel_wd;
                  rr_ptr_q   <= rr_ptr_d;
                  state_q    <= ACCESS;
               end
            end
            ACCESS: begin
               ram_we_q <= 1'b0;
               if (we_q) begin
                  state_q <= IDLE;
               end else begin
                  lat_cnt_q <= CNT_W'(RD_LAT - 1);
                  state_q   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // A non-zero rvalid_q marks the extra return cycle before IDLE.
               if (|rvalid_q) begin
                  rvalid_q <= '0;
                  state_q  <= IDLE;
               end else if (lat_cnt_q == '0) begin
                  rdata_q  <= ram_rd;
                  rvalid_q <= win_oh_q;
               end else begin
                  lat_cnt_q <= lat_cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt      = (state_q == IDLE && !rst) ? pick_oh : '0;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign busy     = (state_q != IDLE);
   assign ram_addr = ram_addr_q;
   assign ram_wd   = ram_wd_q;
   assign ram_we   = ram_we_q;

endmodule
